// File: rtl/load_extend_if.sv
// load_extend_if: beat/result handshake bundle for the load_extend stage.
// The slave modport is the stage itself; the master modport is the side that
// presents memory beats and consumes extended results.
interface load_extend_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OW    = $clog2(BYTES);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OW-1:0]         in_offset;
    logic [1:0]            in_size;
    logic                  in_unsigned;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_fault;

    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
        output in_ready, out_valid, out_data, out_fault
    );

    modport master (
        output in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
        input  in_ready, out_valid, out_data, out_fault
    );
endinterface

// File: rtl/load_extend.sv
// load_extend: load-data alignment and sign/zero extension for the writeback
// path. A raw memory beat is shifted down to the addressed byte lane, masked to
// the access size and extended to DATA_WIDTH; the result sits in an output
// register behind a valid/ready handshake.
//
// Build option: define LOAD_EXT_MISALIGN_EN to reassemble loads that straddle
// a word boundary from two consecutive beats (state HI). Without it such loads
// complete in one beat with out_fault = 1 and out_data = 0.
module load_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    load_extend_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OW    = $clog2(BYTES);

`ifdef LOAD_EXT_MISALIGN_EN
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_HI   = 1'b1;
    localparam logic [OW:0] BYTES_L = (OW+1)'(BYTES);
`endif

    // Mask a right-justified field to the access size and extend it.
    function automatic logic [DATA_WIDTH-1:0] extend_f(
        input logic [DATA_WIDTH-1:0] field,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic                  sign_v;
        int                    nb_v;
        logic [DATA_WIDTH-1:0] res_v;
        case (size)
            2'd0:    begin sign_v = field[7];            nb_v = 1; end
            2'd1:    begin sign_v = field[15];           nb_v = 2; end
            2'd2:    begin sign_v = field[31];           nb_v = 4; end
            default: begin sign_v = field[DATA_WIDTH-1]; nb_v = 8; end
        endcase
        res_v = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < nb_v) begin
                res_v[8*i +: 8] = field[8*i +: 8];
            end else begin
                res_v[8*i +: 8] = {8{sign_v & ~uns}};
            end
        end
        return res_v;
    endfunction

    // Output register
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_fault_r;

    logic                  nxt_valid_s;
    logic [DATA_WIDTH-1:0] nxt_data_s;
    logic                  nxt_fault_s;

`ifdef LOAD_EXT_MISALIGN_EN
    // Split-load capture: low bytes from the first beat plus its attributes
    logic [0:0]            state_r;
    logic [DATA_WIDTH-1:0] lo_r;
    logic [OW-1:0]         off_r;
    logic [1:0]            size_r;
    logic                  uns_r;

    logic [0:0]            nxt_state_s;
    logic [DATA_WIDTH-1:0] nxt_lo_s;
    logic [OW-1:0]         nxt_off_s;
    logic [1:0]            nxt_size_s;
    logic                  nxt_uns_s;

    logic [OW:0]           hi_sh_s;
    logic [DATA_WIDTH-1:0] merged_s;
`endif

    logic                  in_ready_s;
    logic                  accept_s;
    logic [4:0]            nbytes_s;
    logic [4:0]            span_s;
    logic                  illegal_s;
    logic                  split_s;
    logic [DATA_WIDTH-1:0] field_s;

    // Input side can take a beat whenever the output register is free or draining.
    always_comb begin
        in_ready_s = !out_valid_r || bus.out_ready;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Classify the presented beat and shift its addressed lane down to bit 0.
    always_comb begin
        nbytes_s  = 5'd1 << bus.in_size;
        span_s    = 5'(bus.in_offset) + nbytes_s;
        illegal_s = nbytes_s > 5'(BYTES);
        split_s   = span_s > 5'(BYTES);
        field_s   = bus.in_data >> {bus.in_offset, 3'b000};
    end

`ifdef LOAD_EXT_MISALIGN_EN
    // Splice the second beat above the captured low bytes.
    always_comb begin
        hi_sh_s  = BYTES_L - {1'b0, off_r};
        merged_s = lo_r | (bus.in_data << {hi_sh_s, 3'b000});
    end
`endif

    // Next-state and next-output selection for one handshake.
    always_comb begin
        nxt_valid_s = out_valid_r;
        nxt_data_s  = out_data_r;
        nxt_fault_s = out_fault_r;
`ifdef LOAD_EXT_MISALIGN_EN
        nxt_state_s = state_r;
        nxt_lo_s    = lo_r;
        nxt_off_s   = off_r;
        nxt_size_s  = size_r;
        nxt_uns_s   = uns_r;
`endif
        if (accept_s) begin
`ifdef LOAD_EXT_MISALIGN_EN
            if (state_r == ST_HI) begin
                // Second beat: attributes come from the first beat.
                nxt_valid_s = 1'b1;
                nxt_data_s  = extend_f(merged_s, size_r, uns_r);
                nxt_fault_s = 1'b0;
                nxt_state_s = ST_IDLE;
            end else if (illegal_s) begin
                nxt_valid_s = 1'b1;
                nxt_data_s  = '0;
                nxt_fault_s = 1'b1;
            end else if (split_s) begin
                // First beat of a straddling load: hold it, emit nothing.
                nxt_valid_s = 1'b0;
                nxt_lo_s    = field_s;
                nxt_off_s   = bus.in_offset;
                nxt_size_s  = bus.in_size;
                nxt_uns_s   = bus.in_unsigned;
                nxt_state_s = ST_HI;
            end else begin
                nxt_valid_s = 1'b1;
                nxt_data_s  = extend_f(field_s, bus.in_size, bus.in_unsigned);
                nxt_fault_s = 1'b0;
            end
`else
            if (illegal_s || split_s) begin
                nxt_valid_s = 1'b1;
                nxt_data_s  = '0;
                nxt_fault_s = 1'b1;
            end else begin
                nxt_valid_s = 1'b1;
                nxt_data_s  = extend_f(field_s, bus.in_size, bus.in_unsigned);
                nxt_fault_s = 1'b0;
            end
`endif
        end else if (bus.out_ready) begin
            nxt_valid_s = 1'b0;
        end else begin
            nxt_valid_s = out_valid_r;
        end
    end

    // Output register: reset clears everything, flush only drops the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_fault_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= nxt_valid_s;
            out_data_r  <= nxt_data_s;
            out_fault_r <= nxt_fault_s;
        end
    end

`ifdef LOAD_EXT_MISALIGN_EN
    // Split-load state: reset or flush abandons a half-assembled load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lo_r    <= '0;
            off_r   <= '0;
            size_r  <= 2'd0;
            uns_r   <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nxt_state_s;
            lo_r    <= nxt_lo_s;
            off_r   <= nxt_off_s;
            size_r  <= nxt_size_s;
            uns_r   <= nxt_uns_s;
        end
    end
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_fault = out_fault_r;
endmodule

// File: doc/load_extend.md
# load_extend

Load-data alignment and extension stage for the memory writeback path. It is the parametrised successor to the core's combinational sign extender. It takes raw memory read beats, shifts the addressed byte lane down, and sign- or zero-extends byte/half/word/double loads to `DATA_WIDTH`. Results are registered behind a valid/ready handshake. Loads that straddle a word boundary are optionally reassembled from two consecutive beats.

## Interface
- `DATA_WIDTH`, 32: datapath width; legal values 32 or 64. `BYTES = DATA_WIDTH/8`, `OW = $clog2(BYTES)`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discards any in-flight load and the output register.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_data` in `DATA_WIDTH`: raw aligned memory word.
- `in_offset` in `OW`: byte offset of the load within the word. Sampled on the first beat only.
- `in_size` in 2: 0 byte, 1 half, 2 word, 3 double. Sampled on the first beat only.
- `in_unsigned` in 1: 1 zero-extends, 0 sign-extends. Sampled on the first beat only.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out `DATA_WIDTH`: extended load value.
- `out_fault` out 1: qualifies `out_valid`; the load was unsupported and `out_data` is 0.

## Operation
- `nbytes = 1 << in_size`.
- A load is a split load when `in_offset + nbytes > BYTES`.
- A load is illegal when `nbytes > BYTES`, i.e. `in_size` = 3 with `DATA_WIDTH` = 32.
- States are IDLE and HI.
- IDLE, accepting a non-split legal beat:
  - Extraction: `field = in_data >> (8*in_offset)`, masked to `nbytes`.
  - Extension: fill the upper bits with `field[8*nbytes-1]` when signed, with 0 when unsigned.
  - The result is written to the output register with `out_fault` = 0.
- IDLE, accepting an illegal beat: write `out_data` = 0 and `out_fault` = 1. Stay in IDLE.
- IDLE, accepting a split beat with the feature compiled in:
  - Capture `lo = in_data >> (8*in_offset)`, which holds `BYTES - in_offset` valid bytes.
  - Capture size, offset and signedness.
  - Go to HI. No output is produced.
- HI, accepting the second beat:
  - Form `merged = lo | (in_data << 8*(BYTES - offset))`.
  - Mask and extend `merged` as above and write it to the output register.
  - Return to IDLE. The second beat's `in_offset`, `in_size` and `in_unsigned` are ignored.
- Handshake rules:
  - `in_ready = !out_valid || out_ready`, in both IDLE and HI.
  - `out_valid` holds until `out_ready` is high.
  - `out_data` and `out_fault` are stable while `out_valid && !out_ready`.
- `flush` takes priority over everything except `rst`:
  - Next cycle: state is IDLE and `out_valid` = 0.
  - A beat handshaken in the same cycle as `flush` is discarded.
- `rst` has the highest priority. After reset:
  - State is IDLE.
  - `out_valid` = 0, `out_data` = 0, `out_fault` = 0.
  - The captured low bytes are cleared.
  - `in_ready` = 1.
- Reset or flush while in HI abandons the half-assembled load. The next beat is treated as a fresh first beat.

## Timing
- Non-split, illegal or faulting load: `out_valid` rises 1 cycle after the input handshake.
- Split load: `out_valid` rises 1 cycle after the second beat's handshake.
- Throughput is one non-split load per cycle when `out_ready` is held high. A split load costs two input beats.
- A simultaneous output handshake and new input handshake both complete in the same cycle; the register reloads without a bubble.
- No combinational path from `in_*` to `out_*`. `in_ready` depends only on `out_valid` and `out_ready`.

## Configuration
- `LOAD_EXT_MISALIGN_EN` defined: split loads are reassembled from two beats via state HI, as described in Operation.
- `LOAD_EXT_MISALIGN_EN` undefined:
  - The HI state and the capture registers are removed.
  - A split beat is treated like an illegal one: a single beat is consumed, and the result is `out_data` = 0, `out_fault` = 1.
  - The next beat is a fresh load.

## Test plan
All cases use `DATA_WIDTH` = 32.
- Signed byte load: `in_data` = 0x80FF_1234, offset 3, size 0, signed -> next cycle `out_valid` = 1, `out_data` = 0xFFFF_FF80, `out_fault` = 0.
- Unsigned half load: `in_data` = 0xBEEF_0000, offset 2, size 1, unsigned -> `out_data` = 0x0000_BEEF. Repeated signed -> 0xFFFF_BEEF.
- Split word load, macro defined: beat0 = 0x1234_ABCD, offset 2, size 2, then beat1 = 0xEEFF_5678 -> no output after beat0; `out_data` = 0x5678_1234 one cycle after beat1.
- Split word load, macro undefined: the same beat0 -> next cycle `out_fault` = 1, `out_data` = 0. A following aligned word 0xEEFF_5678 at offset 0 -> `out_data` = 0xEEFF_5678.
- Backpressure: `out_ready` held low for 3 cycles with an aligned result pending -> `out_data` stable and `in_ready` = 0 throughout. Raising `out_ready` with a new beat presented -> both handshakes complete that cycle and the new result appears next cycle.
- Flush and reset in HI: flush asserted the cycle after a split beat0 -> `out_valid` stays 0. Then an aligned word 0x0000_0042 at offset 0 -> `out_data` = 0x0000_0042. Repeat the sequence using `rst` instead of `flush` and check all outputs are 0 after reset.
